// File: rtl/audio_line_unpacker_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
// Shared constants and types for the audio line unpacker.
// The DEF_* values are the default build; the modules recompute their own
// derived widths from their parameters so non-default builds stay consistent.
// ----------------------------------------------------------------------------
package audio_pkg;

    localparam int DEF_INW           = 512;
    localparam int DEF_SAMPLEW       = 16;
    localparam int DEF_DEPTH         = 2;
    localparam int DEF_FRAME_SAMPLES = 1024;

    localparam int SAMPLES_PER_LINE  = DEF_INW / DEF_SAMPLEW;
    localparam int IDX_W             = $clog2(SAMPLES_PER_LINE);
    localparam int FCNT_W            = $clog2(DEF_FRAME_SAMPLES);

    typedef logic [DEF_INW-1:0]     audio_line_t;
    typedef logic [DEF_SAMPLEW-1:0] sample_t;

endpackage : audio_pkg

// File: rtl/audio_line_fifo.sv
// ----------------------------------------------------------------------------
// audio_line_fifo
// DEPTH-entry line buffer with registered pointers, occupancy and full flag.
// A push is accepted when a slot is free, or when the FIFO is full and the
// head is popped in the same cycle (the freed slot is reused immediately).
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_req    : request to store line_in this cycle
//   line_in     : line to store
//   pop         : remove the head entry this cycle (ignored when empty)
//   head        : current head entry (registered storage)
//   accepted    : push_req was accepted this cycle
//   full        : registered, all DEPTH slots occupied
//   empty       : no entries held (decoded from registered count)
// ----------------------------------------------------------------------------
module audio_line_fifo
    import audio_pkg::*;
#(
    parameter int INW   = DEF_INW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_req,
    input  logic [INW-1:0] line_in,
    input  logic           pop,
    output logic [INW-1:0] head,
    output logic           accepted,
    output logic           full,
    output logic           empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INW-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_r;

    logic             pop_s;
    logic             accept_s;
    logic [CNT_W-1:0] count_nxt_s;

    assign pop_s    = pop && (count_r != {CNT_W{1'b0}});
    assign accept_s = push_req && ((count_r < CNT_W'(DEPTH)) || pop_s);

    // Next occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({accept_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy and full-flag registers; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
        end
    end

    // Line storage; contents are only observed while count is non-zero,
    // so the array needs no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= line_in;
        end
    end

    assign head     = mem_r[rd_ptr_r];
    assign accepted = accept_s;
    assign full     = full_r;
    assign empty    = (count_r == {CNT_W{1'b0}});

endmodule : audio_line_fifo

// File: rtl/audio_line_unpacker.sv
// ----------------------------------------------------------------------------
// audio_line_unpacker
// Buffers INW-bit audio lines from the CPU writeback stage and serialises each
// into SAMPLEW-bit samples (sample 0 = LSBs) on a valid/ready stream. Pulses
// tx_done after a line drains, flags FFT frame ends with sample_last, and
// pulses overflow when a line arrives with no room for it.
//
// Optional build macro AUDIO_DROP_CNT_EN adds drop_cnt[15:0], a saturating
// count of dropped lines.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   audio_valid   : one-cycle pulse, audio_in holds a new line
//   audio_in      : INW-bit audio line
//   sample_ready  : downstream accepts a sample this cycle
//   sample_valid  : sample_data is valid
//   sample_data   : current sample (0 when nothing buffered)
//   sample_last   : current sample closes an FFT frame
//   tx_done       : one-cycle pulse, a line was fully drained
//   full          : all DEPTH slots occupied
//   overflow      : one-cycle pulse, an incoming line was dropped
//   drop_cnt      : (AUDIO_DROP_CNT_EN only) saturating dropped-line count
// ----------------------------------------------------------------------------
module audio_line_unpacker
    import audio_pkg::*;
#(
    parameter int INW           = DEF_INW,
    parameter int SAMPLEW       = DEF_SAMPLEW,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int FRAME_SAMPLES = DEF_FRAME_SAMPLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               audio_valid,
    input  logic [INW-1:0]     audio_in,
    input  logic               sample_ready,
    output logic               sample_valid,
    output logic [SAMPLEW-1:0] sample_data,
    output logic               sample_last,
    output logic               tx_done,
    output logic               full,
    output logic               overflow
`ifdef AUDIO_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    localparam int N_S    = INW / SAMPLEW;
    localparam int NIDX_W = $clog2(N_S);
    localparam int NFC_W  = $clog2(FRAME_SAMPLES);

    logic [INW-1:0]     head_s;
    logic               accepted_s;
    logic               empty_s;
    logic               xfer_s;
    logic               line_end_s;
    logic               pop_s;
    logic               frame_end_s;
    logic [SAMPLEW-1:0] sample_s;

    logic [NIDX_W-1:0]  idx_r;
    logic [NFC_W-1:0]   fcnt_r;
    logic               tx_done_r;
    logic               overflow_r;

    audio_line_fifo #(
        .INW   (INW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_req (audio_valid),
        .line_in  (audio_in),
        .pop      (pop_s),
        .head     (head_s),
        .accepted (accepted_s),
        .full     (full),
        .empty    (empty_s)
    );

    assign sample_valid = !empty_s;
    assign xfer_s       = sample_valid && sample_ready;
    assign line_end_s   = (idx_r == NIDX_W'(N_S - 1));
    assign frame_end_s  = (fcnt_r == NFC_W'(FRAME_SAMPLES - 1));
    assign pop_s        = xfer_s && line_end_s;

    // Serialisation mux over the registered head line; forced to zero when
    // nothing is buffered so stale storage never reaches the datapath.
    always_comb begin
        sample_s = {SAMPLEW{1'b0}};
        if (sample_valid) begin
            sample_s = head_s[idx_r*SAMPLEW +: SAMPLEW];
        end else begin
            sample_s = {SAMPLEW{1'b0}};
        end
    end

    assign sample_data = sample_s;
    assign sample_last = sample_valid && frame_end_s;

    // Sample index, frame counter and the tx_done / overflow pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r      <= {NIDX_W{1'b0}};
            fcnt_r     <= {NFC_W{1'b0}};
            tx_done_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            tx_done_r  <= pop_s;
            overflow_r <= audio_valid && !accepted_s;
            if (xfer_s) begin
                idx_r  <= line_end_s  ? {NIDX_W{1'b0}} : idx_r + NIDX_W'(1);
                fcnt_r <= frame_end_s ? {NFC_W{1'b0}}  : fcnt_r + NFC_W'(1);
            end else begin
                idx_r  <= idx_r;
                fcnt_r <= fcnt_r;
            end
        end
    end

    assign tx_done  = tx_done_r;
    assign overflow = overflow_r;

`ifdef AUDIO_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of lines dropped for lack of space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 16'h0000;
        end else if (audio_valid && !accepted_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

endmodule : audio_line_unpacker

// File: tb/tb_audio_line_unpacker.sv
// ----------------------------------------------------------------------------
// tb_audio_line_unpacker
// Directed bench for audio_line_unpacker at default parameters. Inputs change
// and outputs are checked 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_audio_line_unpacker;
    import audio_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        audio_valid;
    audio_line_t audio_in;
    logic        sample_ready;
    logic        sample_valid;
    sample_t     sample_data;
    logic        sample_last;
    logic        tx_done;
    logic        full;
    logic        overflow;
`ifdef AUDIO_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_tests;
    int n_fail;

    audio_line_unpacker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_valid  (audio_valid),
        .audio_in     (audio_in),
        .sample_ready (sample_ready),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_last  (sample_last),
        .tx_done      (tx_done),
        .full         (full),
        .overflow     (overflow)
`ifdef AUDIO_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line whose sample k equals base + k.
    function automatic audio_line_t mk_line(input logic [15:0] base);
        audio_line_t l;
        for (int k = 0; k < SAMPLES_PER_LINE; k++) begin
            l[k*16 +: 16] = base + 16'(k);
        end
        return l;
    endfunction

    initial begin
        int e;
        int txc;
        int t;
        int pushed;
        int cyc;
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        audio_valid = 1'b0;
        audio_in = '0;
        sample_ready = 1'b0;

        // ---- reset state ----
        #2;
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_data", 32'(sample_data), 32'd0);
        chk("rst_last", 32'(sample_last), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // ---- single line, ready held high ----
        sample_ready = 1'b1;
        audio_valid = 1'b1;
        audio_in = mk_line(16'h0100);
        chk("s1_valid_before", 32'(sample_valid), 32'd0);
        step();
        audio_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk("s1_valid", 32'(sample_valid), 32'd1);
            chk("s1_data", 32'(sample_data), 32'h0100 + 32'(k));
            chk("s1_tx_idle", 32'(tx_done), 32'd0);
            step();
        end
        chk("s1_tx_done", 32'(tx_done), 32'd1);
        chk("s1_valid_drop", 32'(sample_valid), 32'd0);
        chk("s1_data_empty", 32'(sample_data), 32'd0);
        step();
        chk("s1_tx_once", 32'(tx_done), 32'd0);

        // ---- backpressure: ready toggles every cycle ----
        sample_ready = 1'b0;
        audio_valid = 1'b1;
        audio_in = mk_line(16'h0200);
        step();
        audio_valid = 1'b0;
        e = 0;
        txc = 0;
        for (int c = 0; c < 64; c++) begin
            sample_ready = (c % 2 == 0);
            txc += int'(tx_done);
            if (e < 32) begin
                chk("bp_valid", 32'(sample_valid), 32'd1);
                chk("bp_data", 32'(sample_data), 32'h0200 + 32'(e));
            end
            if (sample_ready && e < 32) e++;
            step();
        end
        txc += int'(tx_done);
        chk("bp_samples", 32'(e), 32'd32);
        chk("bp_tx_count", 32'(txc), 32'd1);
        chk("bp_valid_end", 32'(sample_valid), 32'd0);

        // ---- overflow: three pushes with ready low ----
        sample_ready = 1'b0;
        audio_valid = 1'b1;
        audio_in = mk_line(16'h0300);
        step();
        chk("ov_full_1", 32'(full), 32'd0);
        audio_in = mk_line(16'h0400);
        step();
        chk("ov_full_2", 32'(full), 32'd1);
        chk("ov_none_2", 32'(overflow), 32'd0);
        audio_in = mk_line(16'h0500);
        step();
        audio_valid = 1'b0;
        chk("ov_pulse", 32'(overflow), 32'd1);
        chk("ov_full_3", 32'(full), 32'd1);
        step();
        chk("ov_pulse_end", 32'(overflow), 32'd0);
`ifdef AUDIO_DROP_CNT_EN
        chk("ov_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        sample_ready = 1'b1;
        txc = 0;
        for (int k = 0; k < 64; k++) begin
            txc += int'(tx_done);
            chk("ov_drain", 32'(sample_data), (k < 32) ? 32'h0300 + 32'(k) : 32'h0400 + 32'(k - 32));
            step();
        end
        txc += int'(tx_done);
        chk("ov_tx_count", 32'(txc), 32'd2);
        chk("ov_valid_end", 32'(sample_valid), 32'd0);

        // ---- push at full coinciding with pop of the head ----
        sample_ready = 1'b0;
        audio_valid = 1'b1;
        audio_in = mk_line(16'h0600);
        step();
        audio_in = mk_line(16'h0700);
        step();
        audio_valid = 1'b0;
        chk("pf_full", 32'(full), 32'd1);
        sample_ready = 1'b1;
        for (int k = 0; k < 31; k++) begin
            chk("pf_head", 32'(sample_data), 32'h0600 + 32'(k));
            step();
        end
        chk("pf_last_of_head", 32'(sample_data), 32'h061F);
        audio_valid = 1'b1;
        audio_in = mk_line(16'h0800);
        step();
        audio_valid = 1'b0;
        chk("pf_no_overflow", 32'(overflow), 32'd0);
        chk("pf_full_stays", 32'(full), 32'd1);
        chk("pf_tx_done", 32'(tx_done), 32'd1);
        for (int k = 0; k < 64; k++) begin
            chk("pf_drain", 32'(sample_data), (k < 32) ? 32'h0700 + 32'(k) : 32'h0800 + 32'(k - 32));
            step();
        end
        chk("pf_valid_end", 32'(sample_valid), 32'd0);

        // ---- reset in the middle of a line ----
        sample_ready = 1'b1;
        audio_valid = 1'b1;
        audio_in = mk_line(16'h0900);
        step();
        audio_in = mk_line(16'h0A00);
        for (int k = 0; k < 10; k++) begin
            chk("mr_data", 32'(sample_data), 32'h0900 + 32'(k));
            step();
            audio_valid = 1'b0;
        end
        chk("mr_full_before", 32'(full), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(sample_valid), 32'd0);
        chk("mr_data_zero", 32'(sample_data), 32'd0);
        chk("mr_last", 32'(sample_last), 32'd0);
        chk("mr_tx_done", 32'(tx_done), 32'd0);
        chk("mr_full", 32'(full), 32'd0);
        chk("mr_overflow", 32'(overflow), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mr_idle_valid", 32'(sample_valid), 32'd0);
        end

        // ---- frame boundary: 33 lines streamed, sample value = 0x1000 + transfer ----
        t = 0;
        pushed = 0;
        cyc = 0;
        while (t < 1056 && cyc < 3000) begin
            if (pushed < 33 && !full) begin
                audio_valid = 1'b1;
                audio_in = mk_line(16'h1000 + 16'(pushed * 32));
                pushed++;
            end else begin
                audio_valid = 1'b0;
            end
            if (sample_valid) begin
                chk("fr_data", 32'(sample_data), 32'h1000 + 32'(t));
                chk("fr_last", 32'(sample_last), 32'((t % 1024) == 1023));
                t++;
            end
            step();
            cyc++;
        end
        audio_valid = 1'b0;
        chk("fr_transfers", 32'(t), 32'd1056);
        chk("fr_valid_end", 32'(sample_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_audio_line_unpacker

// File: doc/audio_line_unpacker.md
Name: audio_line_unpacker

Overview:
- Sits directly downstream of the CPU writeback stage. Consumes the 512-bit audio lines the CPU emits with a one-cycle audio_valid pulse.
- Buffers up to DEPTH lines and serialises each line into SAMPLEW-bit samples on a valid/ready stream toward the FFT/synth datapath.
- Returns a one-cycle tx_done pulse to the CPU when a line has been fully drained.
- Marks FFT frame boundaries with sample_last.

Parameters:
- INW, 512, audio line width; must be a multiple of SAMPLEW.
- SAMPLEW, 16, output sample width.
- DEPTH, 2, line buffer depth in lines; power of two, >=2.
- FRAME_SAMPLES, 1024, samples per FFT frame; must be a multiple of INW/SAMPLEW.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- audio_valid  in  1  one-cycle pulse: audio_in holds a new line.
- audio_in  in  INW  audio line from CPU writeback.
- sample_ready  in  1  downstream accepts a sample this cycle.
- sample_valid  out  1  sample_data is valid.
- sample_data  out  SAMPLEW  current sample.
- sample_last  out  1  current sample is the last of an FFT frame.
- tx_done  out  1  one-cycle pulse: a line was fully drained; drives CPU tx_done.
- full  out  1  all DEPTH slots occupied.
- overflow  out  1  one-cycle pulse: an incoming line was dropped.

Behaviour:
- Reset (async assert, sync release): FIFO empty, count=0, rd/wr pointers=0, sample index idx=0, frame counter fcnt=0.
  - All outputs are 0 during reset: sample_valid, sample_data, sample_last, tx_done, full, overflow.
  - Reset mid-line or mid-frame discards all buffered data and restarts the frame at sample 0.
- Definitions: N = INW/SAMPLEW (32 at defaults); xfer = sample_valid && sample_ready.
- Push:
  - On audio_valid, the line is written at wr_ptr if (count < DEPTH) or (count == DEPTH && pop this cycle).
  - Otherwise the line is dropped; overflow is registered and pulses high the next cycle. The FIFO is unchanged.
- Latency: a line pushed at cycle t gives sample_valid=1 at t+1 if the FIFO was empty. Output is registered FIFO storage, no combinational path from audio_in.
- Output:
  - sample_valid = (count != 0).
  - sample_data = head[idx*SAMPLEW +: SAMPLEW]; sample 0 is the LSBs.
  - sample_data = 0 when the FIFO is empty.
  - sample_data holds stable while sample_valid && !sample_ready.
- Index stepping:
  - On xfer with idx < N-1: idx++.
  - On xfer with idx == N-1: idx=0, rd_ptr++, count decrements (pop), and tx_done pulses the next cycle.
- Simultaneous push+pop: count unchanged. Pointers wrap modulo DEPTH.
- Frame:
  - sample_last = sample_valid && (fcnt == FRAME_SAMPLES-1).
  - fcnt increments on xfer and wraps to 0 after FRAME_SAMPLES-1.
  - fcnt is not affected by drops; dropped lines simply never enter the frame.
- full = (count == DEPTH), registered.
- Outputs must not glitch; all are registered or derived from registered state only.

Optional Feature:
- Macro AUDIO_DROP_CNT_EN.
  - Defined: adds output port drop_cnt [15:0]. It increments on each dropped line, saturates at 16'hFFFF, and resets to 0.
  - Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package audio_pkg:
  - Constants SAMPLES_PER_LINE = INW/SAMPLEW, IDX_W = $clog2(SAMPLES_PER_LINE), FCNT_W = $clog2(FRAME_SAMPLES).
  - Typedefs audio_line_t [INW-1:0] and sample_t [SAMPLEW-1:0].
- One sub-module audio_line_fifo holds DEPTH x INW storage, pointers, count, push/pop/full/empty.
- The top level holds the index and frame counters, serialisation mux, and pulse registers.

Test Plan:
- Single line: push line with sample k = 16'h0100+k (k=0..31), sample_ready=1 constantly.
  - Required: sample_valid rises one cycle after the push.
  - Required: 32 consecutive samples 0x0100..0x011F, in order.
  - Required: tx_done pulses exactly once, in the cycle after sample 31; sample_valid then drops.
- Backpressure: toggle sample_ready 1/0 every cycle across one line.
  - Required: sample_data holds on ready=0, no sample skipped or duplicated, tx_done once.
- Overflow: sample_ready=0, push 3 lines (DEPTH=2).
  - Required: full=1 after the 2nd push; overflow pulses once for the 3rd.
  - Required: with ready=1, only lines 1 and 2 drain (64 samples). With AUDIO_DROP_CNT_EN, drop_cnt=1.
- Push-at-full with pop: FIFO full, on the cycle sample 31 of the head is taken, pulse audio_valid.
  - Required: line accepted, no overflow, full stays 1.
- Frame boundary: stream 33 lines, ready=1.
  - Required: sample_last high on the 1024th transfer only (last sample of line 32).
  - Required: the next sample starts a new frame and sample_last stays low until the 2048th transfer.
- Reset mid-line: assert rst_n=0 after 10 samples of a line.
  - Required: all outputs 0 immediately. After release, no sample_valid until a new push; the new line's first sample is index 0 with fcnt=0.
